// File: rtl/i2c_request_arbiter.sv
// Round-robin arbiter sharing one I2C master among N_REQ command producers.
// One 32-bit command is accepted per grant and forwarded on a single valid/ready
// stream. The grant is held until the I2C master reports completion or a
// timeout expires, followed by an enforced bus-free gap.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no grant; round-robin search over req_valid from rr pointer
// ST_GRANT | req_ready pulse to the winner; command latched into out_data
// ST_ISSUE | out_valid held until the writer accepts the command
// ST_WAIT  | waiting for i2c_done; timeout counter running
// ST_GAP   | bus-free gap before the next arbitration
module i2c_request_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 64,
  parameter int ID_WIDTH       = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [32*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic                out_valid,
  output logic [31:0]         out_data,
  input  logic                out_ready,
  input  logic                i2c_done,
  output logic [ID_WIDTH-1:0] grant_id,
  output logic                busy,
  output logic                timeout_error
);

  localparam int MAX_COUNT = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W     = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

  // Last count value of each phase; a zero-length gap exits on the first GAP cycle.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    req_ready_q, req_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_data_q, out_data_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic                busy_q, busy_d;
  logic                timeout_error_q, timeout_error_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                win_found;
  logic [ID_WIDTH-1:0] win_idx;
  logic [N_REQ-1:0]    win_onehot;
  logic [31:0]         win_data;
  logic [ID_WIDTH-1:0] rr_next;
  int                  best_off;
  int                  cand_off;

  // Served requester drops to lowest priority for the next search.
  assign rr_next = ID_WIDTH'((int'(grant_id_q) + 1) % N_REQ);

  // Round-robin pick: smallest distance from rr pointer (with wrap) wins.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_onehot = '0;
    win_data   = '0;
    best_off   = N_REQ;
    cand_off   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_off = (k + N_REQ - int'(rr_q)) % N_REQ;
      if (req_valid[k] && (cand_off < best_off)) begin
        best_off      = cand_off;
        win_found     = 1'b1;
        win_idx       = ID_WIDTH'(k);
        win_onehot    = '0;
        win_onehot[k] = 1'b1;
        win_data      = req_data[32*k +: 32];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d         = state_q;
    req_ready_d     = '0;
    out_valid_d     = out_valid_q;
    out_data_d      = out_data_q;
    grant_id_d      = grant_id_q;
    busy_d          = busy_q;
    timeout_error_d = timeout_error_q;
    rr_d            = rr_q;
    cnt_d           = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          req_ready_d = win_onehot;
          grant_id_d  = win_idx;
          out_data_d  = win_data;
          busy_d      = 1'b1;
          state_d     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        out_valid_d = 1'b1;
        state_d     = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Completion on the final count wins over the timeout.
        if (i2c_done) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else if (cnt_q >= TIMEOUT_LAST) begin
          timeout_error_d = 1'b1;
          cnt_d           = '0;
          state_d         = ST_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q >= GAP_LAST) begin
          busy_d  = 1'b0;
          rr_d    = rr_next;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight command at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      req_ready_q     <= '0;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      grant_id_q      <= '0;
      busy_q          <= 1'b0;
      timeout_error_q <= 1'b0;
      rr_q            <= '0;
      cnt_q           <= '0;
    end else begin
      state_q         <= state_d;
      req_ready_q     <= req_ready_d;
      out_valid_q     <= out_valid_d;
      out_data_q      <= out_data_d;
      grant_id_q      <= grant_id_d;
      busy_q          <= busy_d;
      timeout_error_q <= timeout_error_d;
      rr_q            <= rr_d;
      cnt_q           <= cnt_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign grant_id      = grant_id_q;
  assign busy          = busy_q;
  assign timeout_error = timeout_error_q;

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// Directed bench for i2c_request_arbiter: arbitration order, command
// forwarding, backpressure, done/timeout boundary, gap length, async reset.
module tb_i2c_request_arbiter;

  localparam int N_REQ          = 4;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int GAP_CYCLES     = 16;
  localparam int ID_WIDTH       = 3;

  logic                clock;
  logic                reset;
  logic [N_REQ-1:0]    req_valid;
  logic [32*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                out_valid;
  logic [31:0]         out_data;
  logic                out_ready;
  logic                i2c_done;
  logic [ID_WIDTH-1:0] grant_id;
  logic                busy;
  logic                timeout_error;

  int checks;
  int failures;

  i2c_request_arbiter #(
    .N_REQ(N_REQ),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .GAP_CYCLES(GAP_CYCLES),
    .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .i2c_done(i2c_done),
    .grant_id(grant_id),
    .busy(busy),
    .timeout_error(timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_req(input int k, input logic [31:0] d);
    for (int i = 0; i < N_REQ; i++) begin
      if (i == k) begin
        req_data[32*i +: 32] = d;
        req_valid[i] = 1'b1;
      end
    end
  endtask

  // Waits (bounded) for a req_ready pulse, drops the winner's valid and
  // reports what was seen at the pulse and one cycle later.
  task automatic await_grant(output int idx, output logic [ID_WIDTH-1:0] gid,
                             output logic [31:0] data, output logic [N_REQ-1:0] rdy,
                             output logic ov_grant, output logic [N_REQ-1:0] rdy_next,
                             output logic ov_next, output int waited);
    idx = -1; gid = '0; data = '0; rdy = '0; ov_grant = 1'b0;
    rdy_next = '0; ov_next = 1'b0; waited = 0;
    while (req_ready === '0 && waited < 100) begin
      tick();
      waited++;
    end
    if (req_ready !== '0) begin
      rdy = req_ready; gid = grant_id; data = out_data; ov_grant = out_valid;
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i]) begin
          idx = i;
          req_valid[i] = 1'b0;
        end
      end
      tick();
      rdy_next = req_ready;
      ov_next  = out_valid;
    end
  endtask

  // Handshake immediately, sample i2c_done done_delay edges after the
  // handshake edge, then count cycles until busy falls.
  task automatic finish_txn(input int done_delay, output logic ov_after_hs, output int gap_n);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    ov_after_hs = out_valid;
    for (int i = 1; i < done_delay; i++) tick();
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    gap_n = 0;
    while (busy === 1'b1 && gap_n < 1000) begin
      tick();
      gap_n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = '0; req_data = '0; out_ready = 1'b0; i2c_done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_ready, out_valid, busy, timeout_error} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 0", {req_ready, out_valid, busy, timeout_error});
    end
    checks++;
    if (out_data !== 32'h0 || grant_id !== '0) begin
      failures++;
      $display("FAIL reset_data: got data=%0h id=%0d expected 0/0", out_data, grant_id);
    end
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({req_ready, out_valid, busy, timeout_error} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got %b expected 0", {req_ready, out_valid, busy, timeout_error});
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] words [4];
    int          order2 [3];
    int idx, waited, gap_n;
    logic [ID_WIDTH-1:0] gid;
    logic [31:0] data;
    logic [N_REQ-1:0] rdy, rdy_next;
    logic ov_grant, ov_next, ov_hs;
    words  = '{32'hA1B2_0000, 32'h1111_2222, 32'h3333_4444, 32'hDEAD_BEEF};
    order2 = '{1, 3, 0};
    for (int k = 0; k < 4; k++) put_req(k, words[k]);
    for (int j = 0; j < 4; j++) begin
      await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
      checks++;
      if (idx !== j || gid !== ID_WIDTH'(j)) begin
        failures++;
        $display("FAIL rr_order_%0d: got idx=%0d id=%0d expected %0d", j, idx, gid, j);
      end
      checks++;
      if (data !== words[j]) begin
        failures++;
        $display("FAIL fwd_data_%0d: got %0h expected %0h", j, data, words[j]);
      end
      checks++;
      if ({ov_grant, rdy_next, ov_next} !== {1'b0, {N_REQ{1'b0}}, 1'b1}) begin
        failures++;
        $display("FAIL pulse_shape_%0d: got %b expected %b", j,
                 {ov_grant, rdy_next, ov_next}, {1'b0, {N_REQ{1'b0}}, 1'b1});
      end
      finish_txn(10, ov_hs, gap_n);
      checks++;
      if (ov_hs !== 1'b0 || gap_n !== GAP_CYCLES) begin
        failures++;
        $display("FAIL txn_end_%0d: got ov=%b gap=%0d expected 0/%0d", j, ov_hs, gap_n, GAP_CYCLES);
      end
    end
    // Serve 0 alone so the pointer sits at 1, then contend 0,1,3.
    put_req(0, 32'h0000_0F00);
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    finish_txn(10, ov_hs, gap_n);
    checks++;
    if (idx !== 0 || data !== 32'h0000_0F00) begin
      failures++;
      $display("FAIL solo_0: got idx=%0d data=%0h expected 0/f00", idx, data);
    end
    put_req(0, 32'h0000_0100);
    put_req(1, 32'h0000_0101);
    put_req(3, 32'h0000_0103);
    for (int j = 0; j < 3; j++) begin
      await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
      checks++;
      if (idx !== order2[j] || data !== (32'h0000_0100 + 32'(order2[j]))) begin
        failures++;
        $display("FAIL rr_wrap_%0d: got idx=%0d data=%0h expected %0d", j, idx, data, order2[j]);
      end
      finish_txn(10, ov_hs, gap_n);
    end
  endtask

  task automatic test_single();
    int idx, waited, gap_n, bad;
    logic [ID_WIDTH-1:0] gid;
    logic [31:0] data;
    logic [N_REQ-1:0] rdy, rdy_next;
    logic ov_grant, ov_next, ov_hs;
    put_req(2, 32'h0062_0312);
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    checks++;
    if (rdy !== 4'b0100 || gid !== 3'd2) begin
      failures++;
      $display("FAIL single_grant: got rdy=%b id=%0d expected 0100/2", rdy, gid);
    end
    checks++;
    if (data !== 32'h0062_0312 || rdy_next !== '0 || ov_next !== 1'b1) begin
      failures++;
      $display("FAIL single_issue: got data=%0h rdy=%b ov=%b expected 620312/0000/1",
               data, rdy_next, ov_next);
    end
    bad = 0;
    repeat (5) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 32'h0062_0312) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL single_hold: got %0d bad cycles expected 0", bad);
    end
    finish_txn(100, ov_hs, gap_n);
    checks++;
    if (ov_hs !== 1'b0 || gap_n !== GAP_CYCLES) begin
      failures++;
      $display("FAIL single_gap: got ov=%b gap=%0d expected 0/%0d", ov_hs, gap_n, GAP_CYCLES);
    end
  endtask

  task automatic test_backpressure();
    int idx, waited, gap_n, bad;
    logic [ID_WIDTH-1:0] gid;
    logic [31:0] data;
    logic [N_REQ-1:0] rdy, rdy_next;
    logic ov_grant, ov_next, ov_hs;
    put_req(3, 32'hCAFE_0003);
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    checks++;
    if (idx !== 3) begin
      failures++;
      $display("FAIL bp_grant: got %0d expected 3", idx);
    end
    put_req(1, 32'hB0B0_0001);
    bad = 0;
    repeat (TIMEOUT_CYCLES + 10) begin
      tick();
      if (out_valid !== 1'b1 || out_data !== 32'hCAFE_0003 || req_ready !== '0 ||
          timeout_error !== 1'b0 || busy !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL bp_stall: got %0d bad cycles expected 0", bad);
    end
    finish_txn(20, ov_hs, gap_n);
    checks++;
    if (gap_n !== GAP_CYCLES || timeout_error !== 1'b0) begin
      failures++;
      $display("FAIL bp_end: got gap=%0d err=%b expected %0d/0", gap_n, timeout_error, GAP_CYCLES);
    end
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    checks++;
    if (idx !== 1 || data !== 32'hB0B0_0001) begin
      failures++;
      $display("FAIL bp_next: got idx=%0d data=%0h expected 1/b0b00001", idx, data);
    end
    finish_txn(5, ov_hs, gap_n);
  endtask

  task automatic test_done_boundary();
    int idx, waited, gap_n;
    logic [ID_WIDTH-1:0] gid;
    logic [31:0] data;
    logic [N_REQ-1:0] rdy, rdy_next;
    logic ov_grant, ov_next, ov_hs;
    put_req(0, 32'h0B0D_0000);
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    finish_txn(TIMEOUT_CYCLES, ov_hs, gap_n);
    checks++;
    if (timeout_error !== 1'b0 || gap_n !== GAP_CYCLES || idx !== 0) begin
      failures++;
      $display("FAIL done_on_last: got err=%b gap=%0d idx=%0d expected 0/%0d/0",
               timeout_error, gap_n, idx, GAP_CYCLES);
    end
  endtask

  task automatic test_spurious_done();
    int idx, waited, gap_n;
    logic [ID_WIDTH-1:0] gid;
    logic [31:0] data;
    logic [N_REQ-1:0] rdy, rdy_next;
    logic ov_grant, ov_next, ov_hs;
    i2c_done = 1'b1;
    tick();
    i2c_done = 1'b0;
    repeat (3) tick();
    checks++;
    if ({req_ready, out_valid, busy, timeout_error} !== '0 || grant_id !== 3'd0 ||
        out_data !== 32'h0B0D_0000) begin
      failures++;
      $display("FAIL spurious_done: got ctl=%b id=%0d data=%0h expected 0/0/b0d0000",
               {req_ready, out_valid, busy, timeout_error}, grant_id, out_data);
    end
    put_req(2, 32'h5A5A_0002);
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    checks++;
    if (idx !== 2 || waited !== 1) begin
      failures++;
      $display("FAIL post_spurious_grant: got idx=%0d wait=%0d expected 2/1", idx, waited);
    end
    finish_txn(3, ov_hs, gap_n);
  endtask

  task automatic test_timeout();
    int idx, waited, gap_n;
    logic [ID_WIDTH-1:0] gid;
    logic [31:0] data;
    logic [N_REQ-1:0] rdy, rdy_next;
    logic ov_grant, ov_next, ov_hs;
    logic err_before;
    put_req(3, 32'h7100_0003);
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    put_req(1, 32'h7100_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (TIMEOUT_CYCLES - 1) tick();
    err_before = timeout_error;
    tick();
    checks++;
    if (err_before !== 1'b0 || timeout_error !== 1'b1) begin
      failures++;
      $display("FAIL timeout_edge: got before=%b at=%b expected 0/1", err_before, timeout_error);
    end
    gap_n = 0;
    while (busy === 1'b1 && gap_n < 1000) begin
      tick();
      gap_n++;
    end
    checks++;
    if (gap_n !== GAP_CYCLES) begin
      failures++;
      $display("FAIL timeout_gap: got %0d expected %0d", gap_n, GAP_CYCLES);
    end
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    checks++;
    if (idx !== 1 || waited !== 1 || data !== 32'h7100_0001) begin
      failures++;
      $display("FAIL timeout_recover: got idx=%0d wait=%0d data=%0h expected 1/1/71000001",
               idx, waited, data);
    end
    finish_txn(5, ov_hs, gap_n);
    checks++;
    if (timeout_error !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: got %b expected 1", timeout_error);
    end
  endtask

  task automatic test_async_reset();
    int idx, waited, gap_n;
    logic [ID_WIDTH-1:0] gid;
    logic [31:0] data;
    logic [N_REQ-1:0] rdy, rdy_next;
    logic ov_grant, ov_next, ov_hs;
    put_req(3, 32'h05E7_0003);
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    put_req(1, 32'h05E7_0001);
    put_req(2, 32'h05E7_0002);
    repeat (5) tick();
    checks++;
    if (busy !== 1'b1 || grant_id !== 3'd3) begin
      failures++;
      $display("FAIL pre_reset_wait: got busy=%b id=%0d expected 1/3", busy, grant_id);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({req_ready, out_valid, busy, timeout_error} !== '0 || grant_id !== '0) begin
      failures++;
      $display("FAIL async_reset_wait: got ctl=%b id=%0d expected 0/0",
               {req_ready, out_valid, busy, timeout_error}, grant_id);
    end
    tick();
    reset = 1'b1;
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    checks++;
    if (idx !== 1 || waited !== 1 || data !== 32'h05E7_0001) begin
      failures++;
      $display("FAIL reset_ptr: got idx=%0d wait=%0d data=%0h expected 1/1/5e70001",
               idx, waited, data);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_issue: got ov=%b busy=%b expected 0/0", out_valid, busy);
    end
    tick();
    reset = 1'b1;
    await_grant(idx, gid, data, rdy, ov_grant, rdy_next, ov_next, waited);
    finish_txn(5, ov_hs, gap_n);
    checks++;
    if (idx !== 2 || gap_n !== GAP_CYCLES) begin
      failures++;
      $display("FAIL post_reset_txn: got idx=%0d gap=%0d expected 2/%0d", idx, gap_n, GAP_CYCLES);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_simultaneous();
    test_single();
    test_backpressure();
    test_done_boundary();
    test_spurious_done();
    test_timeout();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_request_arbiter.md
Name: i2c_request_arbiter

Overview:
Round-robin arbiter that shares the single I2C master between N_REQ independent command producers, for example clock-chip configurators and sensor pollers. It accepts one 32-bit write command per grant and forwards it on a single stream toward the stream-to-AXI-lite writer. It then holds the grant until the I2C master reports completion or a timeout expires. A configurable bus-free gap is enforced between transactions.

Parameters:
N_REQ, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 65535, max clock cycles to wait for i2c_done after issue
GAP_CYCLES, 64, idle clock cycles enforced between done/timeout and the next grant
ID_WIDTH, 3, width of grant_id (must satisfy 2^ID_WIDTH >= N_REQ)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester command valid
req_data  in  32*N_REQ  per-requester command word; requester k uses bits [32k+31:32k]
req_ready  out  N_REQ  per-requester accept; one-hot or zero
out_valid  out  1  command valid toward the writer
out_data  out  32  forwarded command word
out_ready  in  1  writer accept
i2c_done  in  1  single-cycle pulse from the I2C master when the transaction ends
grant_id  out  ID_WIDTH  index of the current or last granted requester
busy  out  1  high from grant until the gap ends
timeout_error  out  1  sticky; set on timeout, cleared only by reset

Behaviour:
- Reset values (async, reset=0): state IDLE, req_ready=0, out_valid=0, out_data=0, grant_id=0, busy=0, timeout_error=0, rr pointer=0, counters=0.
- IDLE:
  - Search starts at rr pointer and wraps modulo N_REQ; first index with req_valid=1 wins.
  - Register the winner into grant_id, latch req_data slice into out_data, pulse req_ready[winner] for exactly one cycle, busy=1, go to ISSUE.
  - Decision takes 1 cycle: req_ready rises the cycle after req_valid is sampled. out_valid rises the cycle after the req_ready pulse.
  - No valid requests: stay in IDLE, all outputs held.
- ISSUE: out_valid=1, out_data stable until out_valid&out_ready. On that handshake: out_valid=0, clear timeout counter, go to WAIT.
- WAIT: count cycles.
  - i2c_done=1: go to GAP.
  - Counter reaches TIMEOUT_CYCLES-1 without done: set timeout_error=1, go to GAP.
  - i2c_done asserted on the same cycle as the final count: treat as done, no error.
- GAP:
  - Count GAP_CYCLES cycles, then busy=0, rr pointer=(grant_id+1) mod N_REQ, go to IDLE.
  - With GAP_CYCLES=0, go to IDLE on the next cycle.
- i2c_done in IDLE, ISSUE or GAP: ignored.
- Requester rules:
  - A requester must hold req_valid and req_data until it sees req_ready.
  - Deasserting req_valid without ready is legal; that requester is simply not granted.
- Fairness: a requester that was just served gets lowest priority on the next arbitration. Worst-case wait is N_REQ-1 transactions.
- Reset mid-transaction returns to IDLE immediately; any in-flight command is dropped and req_ready/out_valid go low asynchronously.
- Counters are sized with $clog2(max(TIMEOUT_CYCLES, GAP_CYCLES)+1) and do not wrap.

Test Plan:
1. Single request: req_valid[2]=1, data 0x00620312 -> req_ready[2] one pulse; out_data=0x00620312 with out_valid held until out_ready; grant_id=2. i2c_done after 100 cycles -> busy falls exactly GAP_CYCLES cycles later.
2. Simultaneous requests: all four valid with distinct data, out_ready=1, i2c_done 10 cycles after each issue -> grants in order 0,1,2,3, each forwarded word matching its source. Then requester 0 re-asserts with 1 and 3 -> order 1,3,0 from pointer=1.
3. Backpressure: out_ready=0 for 50 cycles -> out_valid stays high, out_data stable, no timeout counting, no new req_ready.
4. Timeout: no i2c_done with TIMEOUT_CYCLES=200 -> timeout_error=1 exactly 200 cycles after the handshake; the arbiter recovers and serves the next pending request. timeout_error remains set.
5. Boundary: i2c_done on the final timeout cycle -> timeout_error stays 0. Spurious i2c_done in IDLE -> no state change.
6. Async reset asserted during WAIT -> out_valid, req_ready, busy=0 without a clock edge. After release, a pending request is granted from pointer 0.
